// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: register map, bit positions,
// FSM state encoding and the last-index clamp helper.
package led_seq_pkg;

  // Word addresses on the Avalon-MM slave port
  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_STATUS   = 4'd1;
  localparam logic [3:0] ADDR_PRESCALE = 4'd2;
  localparam logic [3:0] ADDR_MANUAL   = 4'd3;
  localparam logic [3:0] ADDR_PAT_BASE = 4'd4;

  // Pattern storage is always sized for the largest configuration so that a
  // 3-bit index selects it cleanly; slots >= NUM_PAT are never written.
  localparam int MAX_PAT = 8;

  // CTRL bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_LOOP    = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int CTRL_IDX_LSB = 4;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_IDX_LSB = 4;
  localparam int STAT_DONE    = 8;

  // PATTERN word: dwell field position
  localparam int PAT_DWELL_LSB = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // Clamp a requested last index into the implemented slot range
  function automatic logic [2:0] clamp_idx(input logic [2:0] idx, input int num_pat);
    if (int'(idx) >= num_pat) return 3'(num_pat - 1);
    return idx;
  endfunction

endpackage

// File: rtl/led_seq_tick.sv
// Prescaler: counts 0..i_prescale while enabled and emits a one-cycle tick
// on the terminal count. The terminal value is read live every cycle.
module led_seq_tick #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_en,
  input  logic [PRESC_W-1:0] i_prescale,
  output logic               o_tick
);

  logic [PRESC_W-1:0] r_cnt;
  logic               w_term;

  // ">=" rather than "==" so that lowering PRESCALE below the current count
  // mid-run wraps at once instead of running the counter all the way round.
  assign w_term = (r_cnt >= i_prescale);
  assign o_tick = i_en && w_term;

  // Count register: cleared on reset/clear, wraps to 0 on terminal count
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_term ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer, Avalon-MM slave. Holds a register file of patterns
// with per-pattern dwell, steps through them on prescaler ticks and raises
// a sticky done flag (optionally as an interrupt) at the end of a one-shot run.
//
// Bus handshake: a write is accepted on every cycle where chipselect is high
// and write_n is low (no wait states, no backpressure); readdata is a pure
// combinational function of address and has no side effects.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int LED_W   = 4,
  parameter int NUM_PAT = 8,
  parameter int PRESC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] out_port,
  output logic             irq,
  output logic             dbg_state
);

  // Register file
  logic               r_loop;
  logic               r_irq_en;
  logic [2:0]         r_last_idx;
  logic [PRESC_W-1:0] r_prescale;
  logic [LED_W-1:0]   r_manual;
  logic [LED_W-1:0]   r_pat_val   [MAX_PAT];
  logic [7:0]         r_pat_dwell [MAX_PAT];
  logic               r_done;

  // Sequencer state
  seq_state_t r_state;
  seq_state_t w_state_nxt;
  logic [2:0] r_cur_idx;
  logic [7:0] r_dwell_cnt;
  logic [2:0] r_sh_last;
  logic       r_sh_loop;

  // Decode
  logic       w_wr;
  logic       w_wr_ctrl;
  logic       w_wr_status;
  logic       w_pat_hit;
  logic [2:0] w_pat_idx;
  logic       w_start;
  logic       w_stop;
  logic       w_tick;
  logic [2:0] w_idx_inc;

  // FSM control strobes
  logic w_load0;
  logic w_advance;
  logic w_wrap_idx;
  logic w_finish;
  logic w_dec;

  logic w_unused;

  assign w_wr        = chipselect && !write_n;
  assign w_wr_ctrl   = w_wr && (address == ADDR_CTRL);
  assign w_wr_status = w_wr && (address == ADDR_STATUS);
  assign w_pat_hit   = (int'(address) >= int'(ADDR_PAT_BASE)) &&
                       (int'(address) <  int'(ADDR_PAT_BASE) + NUM_PAT);
  assign w_pat_idx   = 3'(address - ADDR_PAT_BASE);
  assign w_start     = w_wr_ctrl && writedata[CTRL_START];
  assign w_stop      = w_wr_ctrl && writedata[CTRL_STOP];
  assign w_idx_inc   = r_cur_idx + 3'd1;
  assign w_unused    = ^writedata[31:16];

  // Prescaler runs only in RUN and restarts from 0 on every (re)start
  led_seq_tick #(.PRESC_W(PRESC_W)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_load0 || (r_state == ST_IDLE)),
    .i_en      (r_state == ST_RUN),
    .i_prescale(r_prescale),
    .o_tick    (w_tick)
  );

  // Register file writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_loop     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_last_idx <= 3'd0;
      r_prescale <= '0;
      r_manual   <= '0;
      for (int i = 0; i < MAX_PAT; i++) begin
        r_pat_val[i]   <= '0;
        r_pat_dwell[i] <= 8'd0;
      end
    end else if (w_wr) begin
      if (address == ADDR_CTRL) begin
        r_loop     <= writedata[CTRL_LOOP];
        r_irq_en   <= writedata[CTRL_IRQ_EN];
        r_last_idx <= writedata[CTRL_IDX_LSB +: 3];
      end
      if (address == ADDR_PRESCALE) r_prescale <= writedata[PRESC_W-1:0];
      if (address == ADDR_MANUAL)   r_manual   <= writedata[LED_W-1:0];
      if (w_pat_hit) begin
        r_pat_val[w_pat_idx]   <= writedata[LED_W-1:0];
        r_pat_dwell[w_pat_idx] <= writedata[PAT_DWELL_LSB +: 8];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and control strobes; stop beats start, start beats expiry
  always_comb begin
    w_state_nxt = r_state;
    w_load0     = 1'b0;
    w_advance   = 1'b0;
    w_wrap_idx  = 1'b0;
    w_finish    = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start && !w_stop) begin
          w_state_nxt = ST_RUN;
          w_load0     = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_start) begin
          w_load0 = 1'b1;
        end else if (w_tick) begin
          if (r_dwell_cnt > 8'd1)           w_dec      = 1'b1;
          else if (r_cur_idx < r_sh_last)   w_advance  = 1'b1;
          else if (r_sh_loop)               w_wrap_idx = 1'b1;
          else begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequence index, dwell counter and shadowed loop/last_idx
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_idx   <= 3'd0;
      r_dwell_cnt <= 8'd0;
      r_sh_last   <= 3'd0;
      r_sh_loop   <= 1'b0;
    end else if (w_load0) begin
      // Shadows come from the same CTRL write that carries start
      r_cur_idx   <= 3'd0;
      r_dwell_cnt <= r_pat_dwell[0];
      r_sh_last   <= clamp_idx(writedata[CTRL_IDX_LSB +: 3], NUM_PAT);
      r_sh_loop   <= writedata[CTRL_LOOP];
    end else if (w_advance) begin
      r_cur_idx   <= w_idx_inc;
      r_dwell_cnt <= r_pat_dwell[w_idx_inc];
    end else if (w_wrap_idx) begin
      r_cur_idx   <= 3'd0;
      r_dwell_cnt <= r_pat_dwell[0];
    end else if (w_dec) begin
      r_dwell_cnt <= r_dwell_cnt - 8'd1;
    end
  end

  // Sticky done: completion set has priority over the W1C clear
  always_ff @(posedge clk) begin
    if (reset)                                    r_done <= 1'b0;
    else if (w_finish)                            r_done <= 1'b1;
    else if (w_wr_status && writedata[STAT_DONE]) r_done <= 1'b0;
  end

  // Read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_LOOP]          = r_loop;
        readdata[CTRL_IRQ_EN]        = r_irq_en;
        readdata[CTRL_IDX_LSB +: 3]  = r_last_idx;
      end
      ADDR_STATUS: begin
        readdata[STAT_BUSY]          = (r_state == ST_RUN);
        readdata[STAT_IDX_LSB +: 3]  = r_cur_idx;
        readdata[STAT_DONE]          = r_done;
      end
      ADDR_PRESCALE: readdata[PRESC_W-1:0] = r_prescale;
      ADDR_MANUAL:   readdata[LED_W-1:0]   = r_manual;
      default: begin
        if (w_pat_hit) begin
          readdata[LED_W-1:0]           = r_pat_val[w_pat_idx];
          readdata[PAT_DWELL_LSB +: 8]  = r_pat_dwell[w_pat_idx];
        end
      end
    endcase
  end

  assign out_port  = (r_state == ST_RUN) ? r_pat_val[r_cur_idx] : r_manual;
  assign irq       = r_done && r_irq_en;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl, built with four pattern slots.
module tb_led_seq_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;
  logic        irq;
  logic        dbg_state;

  int n_checks;
  int n_errors;
  logic [3:0]  exp_q[$];
  logic [31:0] rd;

  led_seq_ctrl #(.LED_W(4), .NUM_PAT(4), .PRESC_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver: one write, sampled at the next rising edge
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Scoreboard: one expected LED value per cycle
  task automatic drain_seq(input string tag);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check(tag, 32'(out_port), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    address    = 4'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out", 32'(out_port), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    for (int a = 0; a < 16; a++) begin
      bus_read(4'(a), rd);
      check($sformatf("rst_rd%0d", a), rd, 32'h0);
    end

    // Manual value while idle
    bus_write(4'd3, 32'hA);
    @(negedge clk);
    check("manual_out", 32'(out_port), 32'hA);
    bus_read(4'd3, rd);
    check("manual_rd", rd, 32'h0000000A);

    // Out-of-range addresses, pattern readback
    bus_write(4'd8, 32'hFFFF);
    bus_read(4'd8, rd);
    check("oor_rd8", rd, 32'h0);
    bus_read(4'd12, rd);
    check("oor_rd12", rd, 32'h0);

    // One-shot: 0x1 for 3 ticks x 2 cycles, then done + irq
    bus_write(4'd2, 32'd1);
    bus_write(4'd4, 32'h0301);
    bus_write(4'd5, 32'h0002);
    bus_read(4'd4, rd);
    check("pat0_rd", rd, 32'h0301);
    bus_write(4'd0, 32'h09);
    for (int i = 0; i < 6; i++) exp_q.push_back(4'h1);
    drain_seq("oneshot_out");
    @(negedge clk);
    check("oneshot_end_out", 32'(out_port), 32'hA);
    check("oneshot_irq", 32'(irq), 32'h1);
    bus_read(4'd1, rd);
    check("oneshot_status", rd, 32'h100);
    bus_read(4'd0, rd);
    check("ctrl_rd", rd, 32'h08);
    bus_write(4'd1, 32'h100);
    @(negedge clk);
    check("w1c_irq", 32'(irq), 32'h0);
    bus_read(4'd1, rd);
    check("w1c_status", rd, 32'h0);

    // Loop: 5,A,A repeating, done stays clear
    bus_write(4'd2, 32'd0);
    bus_write(4'd4, 32'h0105);
    bus_write(4'd5, 32'h020A);
    bus_write(4'd0, 32'h15);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(4'h5);
      exp_q.push_back(4'hA);
      exp_q.push_back(4'hA);
    end
    drain_seq("loop_out");
    bus_read(4'd1, rd);
    check("loop_status", rd & 32'h101, 32'h001);

    // Stop during RUN
    bus_write(4'd0, 32'h02);
    check("stop_state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    check("stop_out", 32'(out_port), 32'hA);
    bus_read(4'd1, rd);
    check("stop_status", rd & 32'h101, 32'h000);

    // Clamp: last_idx 7 with four slots wraps after index 3
    bus_write(4'd4, 32'h0101);
    bus_write(4'd5, 32'h0102);
    bus_write(4'd6, 32'h0103);
    bus_write(4'd7, 32'h0104);
    bus_write(4'd0, 32'h75);
    for (int i = 0; i < 10; i++) exp_q.push_back(4'(i % 4 + 1));
    drain_seq("clamp_out");

    // Start and stop together while running
    bus_write(4'd0, 32'h03);
    @(negedge clk);
    check("ss_out", 32'(out_port), 32'hA);
    bus_read(4'd1, rd);
    check("ss_busy", rd & 32'h1, 32'h0);

    // W1C on the completion edge: set wins
    bus_write(4'd4, 32'h0301);
    bus_write(4'd0, 32'h09);
    repeat (2) @(posedge clk);
    bus_write(4'd1, 32'h100);
    bus_read(4'd1, rd);
    check("coll_status", rd, 32'h100);
    check("coll_irq", 32'(irq), 32'h1);
    bus_write(4'd1, 32'h100);
    bus_read(4'd1, rd);
    check("coll_clear", rd, 32'h0);

    // Reset mid-run
    bus_write(4'd0, 32'h15);
    @(negedge clk);
    check("pre_rst_state", 32'(dbg_state), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out", 32'(out_port), 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'h0);
    bus_read(4'd1, rd);
    check("mid_rst_status", rd, 32'h0);
    bus_read(4'd4, rd);
    check("mid_rst_pat0", rd, 32'h0);
    bus_read(4'd0, rd);
    check("mid_rst_ctrl", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
